// File: rtl/ascon_aead_sequencer_if.sv
// Handshake and datapath-control bundle for the ASCON-AEAD128 sequencer.
// Optional abort ports exist only when ASCON_SEQ_ABORT_EN is defined.
interface ascon_aead_sequencer_if #(
   parameter int unsigned DATA_W = 128
);
   logic              start_i;
   logic              ad_present_i;
   logic [DATA_W-1:0] block_i;
   logic              block_valid_i;
   logic              block_last_i;
   logic              block_ready_o;
   logic [DATA_W-1:0] data_o;
   logic              init_p_o;
   logic [3:0]        round_p_o;
   logic              enable_p_o;
   logic              enable_xor_b_o;
   logic              final_key_o;
   logic [1:0]        enable_xor_e_o;
   logic              enable_cipher_o;
   logic              enable_tag_o;
   logic              busy_o;
   logic              done_o;
`ifdef ASCON_SEQ_ABORT_EN
   logic              abort_i;
   logic              aborted_o;
`endif

   // master drives messages and blocks; slave is the sequencer
   modport master (
      output start_i, ad_present_i, block_i, block_valid_i, block_last_i,
`ifdef ASCON_SEQ_ABORT_EN
      output abort_i,
      input  aborted_o,
`endif
      input  block_ready_o, data_o, init_p_o, round_p_o, enable_p_o,
             enable_xor_b_o, final_key_o, enable_xor_e_o, enable_cipher_o,
             enable_tag_o, busy_o, done_o
   );

   modport slave (
      input  start_i, ad_present_i, block_i, block_valid_i, block_last_i,
`ifdef ASCON_SEQ_ABORT_EN
      input  abort_i,
      output aborted_o,
`endif
      output block_ready_o, data_o, init_p_o, round_p_o, enable_p_o,
             enable_xor_b_o, final_key_o, enable_xor_e_o, enable_cipher_o,
             enable_tag_o, busy_o, done_o
   );
endinterface

// File: rtl/ascon_aead_sequencer.sv
// Control FSM for the ASCON-AEAD128 round datapath: one round per cycle, block buffering, strobes.
// Optional feature: define ASCON_SEQ_ABORT_EN to add abort_i/aborted_o.
module ascon_aead_sequencer #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 8,
   parameter int unsigned DATA_W   = 128
) (
   input logic                    clock_i,
   input logic                    reset_i,
   ascon_aead_sequencer_if.slave  bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ROUNDS_A - 1);
   localparam logic [CNT_W-1:0] LAST_B = CNT_W'(ROUNDS_B - 1);
   localparam logic [CNT_W-1:0] BASE_A = CNT_W'(12 - ROUNDS_A);
   localparam logic [CNT_W-1:0] BASE_B = CNT_W'(12 - ROUNDS_B);

   typedef enum logic [2:0] {
      IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
   } state_t;

   state_t            state_q, state_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              ad_q, ad_n;
   logic              last_q, last_n;
   logic [DATA_W-1:0] data_q, data_n;

   logic              ready_q, ready_n;
   logic              init_q, init_n;
   logic [CNT_W-1:0]  round_q, round_n;
   logic              en_q, en_n;
   logic              xor_b_q, xor_b_n;
   logic              fkey_q, fkey_n;
   logic [1:0]        xor_e_q, xor_e_n;
   logic              cipher_q, cipher_n;
   logic              tag_q, tag_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
`ifdef ASCON_SEQ_ABORT_EN
   logic              aborted_q, aborted_n;
`endif

   // State, counter, block buffer and registered outputs
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ad_q      <= 1'b0;
         last_q    <= 1'b0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         init_q    <= 1'b0;
         round_q   <= '0;
         en_q      <= 1'b0;
         xor_b_q   <= 1'b0;
         fkey_q    <= 1'b0;
         xor_e_q   <= 2'b00;
         cipher_q  <= 1'b0;
         tag_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef ASCON_SEQ_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         ad_q      <= ad_n;
         last_q    <= last_n;
         data_q    <= data_n;
         ready_q   <= ready_n;
         init_q    <= init_n;
         round_q   <= round_n;
         en_q      <= en_n;
         xor_b_q   <= xor_b_n;
         fkey_q    <= fkey_n;
         xor_e_q   <= xor_e_n;
         cipher_q  <= cipher_n;
         tag_q     <= tag_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
`ifdef ASCON_SEQ_ABORT_EN
         aborted_q <= aborted_n;
`endif
      end
   end

   // Next state, then outputs decoded from the next state so they line up with it
   always_comb begin
      state_n  = state_q;
      cnt_n    = '0;
      ad_n     = ad_q;
      last_n   = last_q;
      data_n   = data_q;
      ready_n  = 1'b0;
      init_n   = 1'b0;
      round_n  = '0;
      en_n     = 1'b0;
      xor_b_n  = 1'b0;
      fkey_n   = 1'b0;
      xor_e_n  = 2'b00;
      cipher_n = 1'b0;
      tag_n    = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
`ifdef ASCON_SEQ_ABORT_EN
      aborted_n = 1'b0;
`endif

      case (state_q)
         IDLE: if (bus.start_i) begin
            state_n = INIT;
            ad_n    = bus.ad_present_i;
         end
         INIT: begin
            if (cnt_q == LAST_A) state_n = ad_q ? WAIT_AD : WAIT_PT;
            else                 cnt_n   = cnt_q + CNT_W'(1);
         end
         WAIT_AD: if (bus.block_valid_i) begin
            data_n  = bus.block_i;
            last_n  = bus.block_last_i;
            state_n = AD;
         end
         AD: begin
            if (cnt_q == LAST_B) state_n = last_q ? WAIT_PT : WAIT_AD;
            else                 cnt_n   = cnt_q + CNT_W'(1);
         end
         WAIT_PT: if (bus.block_valid_i) begin
            data_n  = bus.block_i;
            last_n  = bus.block_last_i;
            state_n = bus.block_last_i ? FINAL : PT;
         end
         PT: begin
            if (cnt_q == LAST_B) state_n = WAIT_PT;
            else                 cnt_n   = cnt_q + CNT_W'(1);
         end
         FINAL: begin
            if (cnt_q == LAST_A) state_n = DONE;
            else                 cnt_n   = cnt_q + CNT_W'(1);
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

`ifdef ASCON_SEQ_ABORT_EN
      // Abort wins over everything, including a block transfer in the same cycle
      if (bus.abort_i && (state_q != IDLE)) begin
         state_n   = IDLE;
         cnt_n     = '0;
         data_n    = data_q;
         last_n    = last_q;
         aborted_n = 1'b1;
      end
`endif

      busy_n = (state_n != IDLE);
      case (state_n)
         INIT: begin
            en_n    = 1'b1;
            round_n = BASE_A + cnt_n;
            init_n  = (cnt_n == '0);
            if (cnt_n == LAST_A) xor_e_n = ad_n ? 2'b01 : 2'b11;
         end
         WAIT_AD, WAIT_PT: ready_n = 1'b1;
         AD: begin
            en_n    = 1'b1;
            round_n = BASE_B + cnt_n;
            xor_b_n = (cnt_n == '0);
            if ((cnt_n == LAST_B) && last_n) xor_e_n = 2'b10;
         end
         PT: begin
            en_n     = 1'b1;
            round_n  = BASE_B + cnt_n;
            xor_b_n  = (cnt_n == '0);
            cipher_n = (cnt_n == '0);
         end
         FINAL: begin
            en_n     = 1'b1;
            round_n  = BASE_A + cnt_n;
            xor_b_n  = (cnt_n == '0);
            cipher_n = (cnt_n == '0);
            fkey_n   = (cnt_n == '0);
            if (cnt_n == LAST_A) begin
               xor_e_n = 2'b01;
               tag_n   = 1'b1;
            end
         end
         DONE:    done_n = 1'b1;
         default: ;
      endcase
   end

   assign bus.block_ready_o   = ready_q;
   assign bus.data_o          = data_q;
   assign bus.init_p_o        = init_q;
   assign bus.round_p_o       = round_q;
   assign bus.enable_p_o      = en_q;
   assign bus.enable_xor_b_o  = xor_b_q;
   assign bus.final_key_o     = fkey_q;
   assign bus.enable_xor_e_o  = xor_e_q;
   assign bus.enable_cipher_o = cipher_q;
   assign bus.enable_tag_o    = tag_q;
   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
`ifdef ASCON_SEQ_ABORT_EN
   assign bus.aborted_o       = aborted_q;
`endif
endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Bench for ascon_aead_sequencer: message plans expand into per-cycle stimulus/expectation queues.
// Covers ASCON_SEQ_ABORT_EN when the macro is defined.
module tb_ascon_aead_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ascon_aead_sequencer_if #(.DATA_W(128)) bus ();

   ascon_aead_sequencer #(.ROUNDS_A(12), .ROUNDS_B(8), .DATA_W(128)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   typedef struct packed {
      logic start, ad, valid, last, abort;
      logic [127:0] blk;
   } stim_t;

   typedef struct packed {
      logic ready;
      logic [127:0] data;
      logic init;
      logic [3:0] rnd;
      logic en, xb, fk;
      logic [1:0] xe;
      logic ciph, tag, busy, done, aborted;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   logic [127:0] m_data = '0;
   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   localparam logic [127:0] PIN_BLK = 128'h0123456789ABCDEF0123456789ABCDEF;

   function automatic stim_t noise();
      stim_t s;
      s.start = 1'($urandom % 2);
      s.ad    = 1'($urandom % 2);
      s.valid = 1'($urandom % 2);
      s.last  = 1'($urandom % 2);
      s.abort = 1'b0;
      s.blk   = {$urandom, $urandom, $urandom, $urandom};
      return s;
   endfunction

   function automatic exp_t base(input logic busy);
      exp_t e = '0;
      e.busy = busy;
      e.data = m_data;
      return e;
   endfunction

   task automatic push(input stim_t s, input exp_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // Wait phase: ready high, valid withheld for 'gap' cycles, then the block transfers
   task automatic wait_block(input int gap, input logic last, input logic [127:0] blk);
      stim_t s;
      exp_t  e;
      for (int w = 0; w <= gap; w++) begin
         s = noise();
         s.valid = (w == gap);
         if (w == gap) begin
            s.last = last;
            s.blk  = blk;
         end
         e = base(1'b1);
         e.ready = 1'b1;
         push(s, e);
      end
      m_data = blk;
   endtask

   task automatic gen_msg(input int nad, input int npt, input int mingap, input int maxgap,
                          input int abort_rnd, input logic force_blk);
      stim_t s;
      exp_t  e;
      logic [127:0] blk;
      s = noise();
      s.start = 1'b1;
      s.ad    = (nad > 0);
      push(s, base(1'b0));
      for (int r = 0; r < 12; r++) begin
         e = base(1'b1);
         e.en = 1'b1; e.rnd = 4'(r); e.init = (r == 0);
         if (r == 11) e.xe = (nad > 0) ? 2'b01 : 2'b11;
         push(noise(), e);
      end
      for (int b = 0; b < nad; b++) begin
         blk = force_blk ? PIN_BLK : {$urandom, $urandom, $urandom, $urandom};
         wait_block($urandom_range(maxgap, mingap), (b == nad - 1), blk);
         for (int r = 0; r < 8; r++) begin
            e = base(1'b1);
            e.en = 1'b1; e.rnd = 4'(4 + r); e.xb = (r == 0);
            if (r == 7 && b == nad - 1) e.xe = 2'b10;
            push(noise(), e);
         end
      end
      for (int b = 0; b < npt; b++) begin
         blk = force_blk ? PIN_BLK : {$urandom, $urandom, $urandom, $urandom};
         wait_block($urandom_range(maxgap, mingap), (b == npt - 1), blk);
         if (b != npt - 1) begin
            for (int r = 0; r < 8; r++) begin
               e = base(1'b1);
               e.en = 1'b1; e.rnd = 4'(4 + r); e.xb = (r == 0); e.ciph = (r == 0);
               push(noise(), e);
            end
         end else begin
            for (int r = 0; r < 12; r++) begin
               e = base(1'b1);
               e.en = 1'b1; e.rnd = 4'(r);
               e.xb = (r == 0); e.ciph = (r == 0); e.fk = (r == 0);
               if (r == 11) begin e.xe = 2'b01; e.tag = 1'b1; end
               if (r == abort_rnd) begin
                  s = noise(); s.abort = 1'b1;
                  push(s, e);
                  s = '0;
                  e = base(1'b0); e.aborted = 1'b1;
                  push(s, e);
                  return;
               end
               push(noise(), e);
            end
         end
      end
      e = base(1'b1);
      e.done = 1'b1;
      push(noise(), e);
   endtask

   task automatic gen_idle(input int n);
      stim_t s;
      for (int i = 0; i < n; i++) begin
         s = '0;
         s.valid = 1'($urandom % 2);
         s.abort = 1'($urandom % 2);
         s.blk   = {$urandom, $urandom, $urandom, $urandom};
         push(s, base(1'b0));
      end
   endtask

   task automatic drive(input stim_t s);
      bus.start_i       = s.start;
      bus.ad_present_i  = s.ad;
      bus.block_valid_i = s.valid;
      bus.block_last_i  = s.last;
      bus.block_i       = s.blk;
`ifdef ASCON_SEQ_ABORT_EN
      bus.abort_i       = s.abort;
`endif
   endtask

   function automatic exp_t sample();
      exp_t a;
      a.ready = bus.block_ready_o;
      a.data  = bus.data_o;
      a.init  = bus.init_p_o;
      a.rnd   = bus.round_p_o;
      a.en    = bus.enable_p_o;
      a.xb    = bus.enable_xor_b_o;
      a.fk    = bus.final_key_o;
      a.xe    = bus.enable_xor_e_o;
      a.ciph  = bus.enable_cipher_o;
      a.tag   = bus.enable_tag_o;
      a.busy  = bus.busy_o;
      a.done  = bus.done_o;
`ifdef ASCON_SEQ_ABORT_EN
      a.aborted = bus.aborted_o;
`else
      a.aborted = 1'b0;
`endif
      return a;
   endfunction

   task automatic check_out(input string name, input exp_t want);
      exp_t got;
      got = sample();
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
      end
   endtask

   task automatic pin(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL pin %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Play the queued plan: drive after the rising edge, compare at the falling edge
   task automatic run_all();
      stim_t s;
      exp_t  e;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(posedge clk);
         #1 drive(s);
         @(negedge clk);
         check_out("cycle", e);
         cyc++;
      end
      drive('0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive('0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_out("reset", '0);
      #1 rst = 1'b0;

      // No AD, one PT block: pin the model timeline first
      gen_msg(0, 1, 0, 0, -1, 1'b0);
      pin("len", exp_q.size(), 27);
      pin("init@1", int'(exp_q[1].init), 1);
      pin("xe@12", int'(exp_q[12].xe), 3);
      pin("ready@12", int'(exp_q[12].ready), 0);
      pin("ready@13", int'(exp_q[13].ready), 1);
      pin("first_final@14", int'({exp_q[14].xb, exp_q[14].ciph, exp_q[14].fk}), 7);
      pin("tag@25", int'(exp_q[25].tag), 1);
      pin("done@26", int'(exp_q[26].done), 1);
      run_all();

      // 2 AD + 2 PT, no gaps, fixed block value
      gen_msg(2, 2, 0, 0, -1, 1'b1);
      pin("ad_round0", int'(exp_q[14].rnd), 4);
      pin("ad1_xe", int'(exp_q[21].xe), 0);
      pin("ad2_xe", int'(exp_q[30].xe), 2);
      run_all();
      gen_idle(2);
      run_all();

      // Backpressure: five idle wait cycles before every block
      gen_msg(1, 3, 5, 5, -1, 1'b0);
      run_all();

      // Reset mid-AD at counter position 6, then restart
      gen_msg(1, 1, 0, 0, -1, 1'b0);
      while (stim_q.size() > 21) begin
         void'(stim_q.pop_back());
         void'(exp_q.pop_back());
      end
      run_all();
      #1 rst = 1'b1;
      #1 check_out("async_reset", '0);
      #1 rst = 1'b0;
      m_data = '0;
      gen_msg(1, 2, 0, 2, -1, 1'b0);
      run_all();

`ifdef ASCON_SEQ_ABORT_EN
      // Abort during FINAL round 3: IDLE next cycle, no tag, no done
      gen_msg(0, 1, 0, 0, 3, 1'b0);
      pin("abort_len", exp_q.size(), 19);
      pin("abort_pulse", int'(exp_q[18].aborted), 1);
      run_all();
      gen_idle(3);
      run_all();
`endif

      // Randomized messages
      for (int m = 0; m < 30; m++) begin
         gen_msg($urandom_range(3, 0), $urandom_range(4, 1), 0, 3, -1, 1'b0);
         gen_idle($urandom_range(2, 0));
         run_all();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
